// File: rtl/uart_seq_trig_rx.sv
// UART receive trigger: deserialises RX at a runtime baud divisor with optional parity,
// keeps a sliding window of the last SEQ_LEN good bytes and pulses UARTtrig on a masked match.
module uart_seq_trig_rx #(
  parameter int DATA_BITS = 8,
  parameter int SEQ_LEN   = 2,
  parameter int BAUD_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           RX,
  input  logic [BAUD_W-1:0]              baud_cnt,
  input  logic [SEQ_LEN*DATA_BITS-1:0]   match,
  input  logic [SEQ_LEN*DATA_BITS-1:0]   mask,
  input  logic                           parity_en,
  input  logic                           parity_odd,
  output logic [DATA_BITS-1:0]           rx_data,
  output logic                           rx_rdy,
  output logic                           frame_err,
  output logic                           parity_err,
  output logic                           UARTtrig
);

  localparam int WIN_W = SEQ_LEN * DATA_BITS;
  localparam int VW    = $clog2(SEQ_LEN + 1);
  localparam int BW    = $clog2(DATA_BITS);
  localparam logic [VW-1:0] VALID_FULL = VW'(SEQ_LEN);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_n;
  logic                 rx_s1, rx_s2, rx_d;
  logic                 rx_fall;
  logic [BAUD_W-1:0]    cnt;
  logic                 tick;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic [WIN_W-1:0]     win, win_next;
  logic [VW-1:0]        valid, valid_next;
  logic                 hit;

  // Synchroniser and edge-detect flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value; blocking here would collapse the chain.
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;
  assign tick    = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
    state_n = state;
    case (state)
      S_IDLE:   if (rx_fall) state_n = S_START;
      S_START:  if (tick) state_n = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_idx == LAST_BIT) state_n = parity_en ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_n = S_STOP;
      S_STOP:   if (tick) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Window as it would look once the byte now in the shifter is accepted.
  always_comb begin
    win_next   = (win << DATA_BITS) | WIN_W'(shreg);
    valid_next = (valid == VALID_FULL) ? valid : valid + VW'(1);
    hit        = (((win_next ^ match) & ~mask) == '0) && (valid_next == VALID_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      // NOTE: the window is a handful of flops, not a RAM, so it is reset to give a defined empty history.
      win        <= '0;
      valid      <= '0;
      rx_data    <= '0;
      rx_rdy     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      UARTtrig   <= 1'b0;
    end else begin
      rx_rdy     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      UARTtrig   <= 1'b0;
      if (state == S_IDLE) begin
        if (rx_fall) begin
          cnt     <= baud_cnt >> 1;
          par_bad <= 1'b0;
        end
      end else if (!tick) begin
        cnt <= cnt - BAUD_W'(1);
      end else begin
        cnt <= baud_cnt;
        case (state)
          S_START:  bit_idx <= '0;
          S_DATA: begin
            shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + BW'(1);
          end
          S_PARITY: par_bad <= (((^shreg) ^ rx_s2) != parity_odd);
          S_STOP: begin
            if (!rx_s2) begin
              frame_err <= 1'b1;
              valid     <= '0;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              valid      <= '0;
            end else begin
              rx_data  <= shreg;
              rx_rdy   <= 1'b1;
              win      <= win_next;
              valid    <= valid_next;
              UARTtrig <= hit;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_seq_trig_rx.sv
// Self-checking bench for uart_seq_trig_rx: directed and randomised frames against a
// byte-history model of the sliding-window trigger.
module tb_uart_seq_trig_rx;

  localparam int BAUD = 108;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [15:0] baud_cnt = 16'(BAUD);
  logic [15:0] match = 16'hA55A;
  logic [15:0] mask = 16'h0000;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_rdy, frame_err, parity_err, UARTtrig;

  uart_seq_trig_rx #(.DATA_BITS(8), .SEQ_LEN(2), .BAUD_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .baud_cnt(baud_cnt),
    .match(match), .mask(mask), .parity_en(parity_en), .parity_odd(parity_odd),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .frame_err(frame_err),
    .parity_err(parity_err), .UARTtrig(UARTtrig)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_rdy = 0, n_trig = 0, n_ferr = 0, n_perr = 0, n_lone = 0;

  always @(negedge clk) begin
    if (rx_rdy)     n_rdy++;
    if (UARTtrig)   n_trig++;
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
    if (UARTtrig && !rx_rdy) n_lone++;
  end

  // Reference model: history of good bytes since the last error, newest at the back.
  logic [7:0] hist[$];
  logic [7:0] last_good = 8'h00;

  function automatic bit model_trig();
    logic [15:0] pat;
    if (hist.size() < 2) return 1'b0;
    pat = {hist[hist.size()-2], hist[hist.size()-1]};
    return ((pat ^ match) & ~mask) == 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    RX = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_val);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (parity_en) drive_bit((^d) ^ parity_odd ^ bad_par);
    drive_bit(stop_val);
    RX = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] d, input bit bad_par, input bit stop_val);
    int r0, t0, f0, p0;
    bit good, exp_trig, exp_ferr, exp_perr;
    r0 = n_rdy; t0 = n_trig; f0 = n_ferr; p0 = n_perr;
    good     = stop_val && !(parity_en && bad_par);
    exp_ferr = !stop_val;
    exp_perr = stop_val && parity_en && bad_par;
    if (good) begin
      hist.push_back(d);
      if (hist.size() > 2) void'(hist.pop_front());
      exp_trig  = model_trig();
      last_good = d;
    end else begin
      hist.delete();
      exp_trig = 1'b0;
    end
    send_frame(d, bad_par, stop_val);
    #1;
    check({tag, ".rdy"},  n_rdy - r0,  good);
    check({tag, ".trig"}, n_trig - t0, exp_trig);
    check({tag, ".ferr"}, n_ferr - f0, exp_ferr);
    check({tag, ".perr"}, n_perr - p0, exp_perr);
    check({tag, ".data"}, rx_data, last_good);
    check({tag, ".lone"}, n_lone, 0);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, ".rx_data"}, rx_data, 8'h00);
    check({tag, ".pulses"}, {rx_rdy, frame_err, parity_err, UARTtrig}, 4'b0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (4) @(negedge clk);
    hist.delete();
    last_good = 8'h00;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, t0, f0, p0;
    logic [7:0] d;
    bit bp, sv;

    // Reset state
    repeat (4) @(negedge clk);
    check_quiet_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: A5 then 5A triggers on the second byte
    frame_chk("t1a", 8'hA5, 0, 1);
    frame_chk("t1b", 8'h5A, 0, 1);

    // 2: wrong order, then masked patterns
    frame_chk("t2a", 8'h5A, 0, 1);
    frame_chk("t2b", 8'hA5, 0, 1);
    mask = 16'h00FF;
    frame_chk("t2c", 8'h33, 0, 1);
    frame_chk("t2d", 8'h5A, 0, 1);
    mask = 16'hFF00;
    frame_chk("t2e", 8'h33, 0, 1);
    frame_chk("t2f", 8'h5A, 0, 1);
    mask = 16'h0000;

    // 3: overlapping occurrences, then a lone byte after reset
    match = 16'h5555;
    frame_chk("t3a", 8'h55, 0, 1);
    frame_chk("t3b", 8'h55, 0, 1);
    frame_chk("t3c", 8'h55, 0, 1);
    do_reset();
    frame_chk("t3d", 8'h55, 0, 1);

    // 4: framing error clears the history
    match = 16'hA55A;
    frame_chk("t4a", 8'hA5, 0, 1);
    frame_chk("t4b", 8'hC3, 0, 0);
    frame_chk("t4c", 8'h5A, 0, 1);

    // 5: parity error, then correct parity triggers
    parity_en = 1'b1;
    parity_odd = 1'b0;
    frame_chk("t5a", 8'hA5, 1, 1);
    frame_chk("t5b", 8'hA5, 0, 1);
    frame_chk("t5c", 8'h5A, 0, 1);
    parity_odd = 1'b1;
    frame_chk("t5d", 8'hA5, 0, 1);
    frame_chk("t5e", 8'h5A, 0, 1);
    parity_en = 1'b0;

    // 6a: short low glitch is a false start
    r0 = n_rdy; t0 = n_trig; f0 = n_ferr; p0 = n_perr;
    @(negedge clk);
    RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    check("glitch.pulses", (n_rdy - r0) + (n_trig - t0) + (n_ferr - f0) + (n_perr - p0), 0);

    // 6b: reset in the middle of the data bits
    @(negedge clk);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet_outputs("midreset");
    RX = 1'b1;
    hist.delete();
    last_good = 8'h00;
    r0 = n_rdy; t0 = n_trig; f0 = n_ferr; p0 = n_perr;
    rst_n = 1'b1;
    repeat (BAUD * 12) @(negedge clk);
    #1;
    check("midreset.pulses", (n_rdy - r0) + (n_trig - t0) + (n_ferr - f0) + (n_perr - p0), 0);
    frame_chk("t6a", 8'hA5, 0, 1);
    frame_chk("t6b", 8'h5A, 0, 1);

    // Randomised frames against the model
    for (int i = 0; i < 14; i++) begin
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) match = 16'($urandom);
      mask = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0000;
      case ($urandom_range(0, 2))
        0:       d = match[15:8];
        1:       d = match[7:0];
        default: d = 8'($urandom);
      endcase
      bp = parity_en && ($urandom_range(0, 5) == 0);
      sv = ($urandom_range(0, 7) != 0);
      frame_chk($sformatf("rnd%0d", i), d, bp, sv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
